draw_bg_starfield: RTL and testbench
====================================

Name: draw_bg_starfield

Overview:
- Parametrised successor to the solid-colour background stage: first block in the VGA pixel pipeline, fed directly by the timing generator.
- Draws a configurable background colour plus up to NUM_LAYERS pseudo-random star layers, each scrolling vertically at its own speed, with per-star twinkle.
- Drives vga_if.out with all timing signals delayed to match the pixel path.

Parameters:
- BG_COLOR, 12'h0_0_1, RGB444 background colour in the active area.
- NUM_LAYERS, 3, number of star layers (1..4); layer k scrolls k+1 lines per frame.
- CELL_LOG2, 4, star grid cell size is 2^CELL_LOG2 pixels square (3..5).
- DENSITY, 3, star present in a cell when hash[15:12] < DENSITY (0..16).
- SEED, 16'hACE1, base seed XORed into every layer hash.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- hcount  in  11  horizontal pixel position
- vcount  in  11  vertical line position
- hblnk  in  1  horizontal blanking
- vblnk  in  1  vertical blanking
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- mode  in  2  00 solid, 01 static stars, 10 scrolling stars, 11 frozen (stars drawn, scroll held)
- vga_out  vga_if.out  -  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb[11:0]

Behaviour:
- Reset (rst=1 at a clk edge): all vga_out fields 0; frame_cnt, scroll offsets, pipeline registers and vsync_d all 0.
- Latency: exactly 2 clk from input to vga_out for every field; timing signals pass through a 2-stage delay unchanged.
- Frame tick: vsync_d is vsync registered; tick = vsync & ~vsync_d (rising edge). On tick, frame_cnt (8 bit) increments, wrapping 255->0.
- Scroll: on tick with mode==10, offset[k] <= offset[k] + (k+1), 11-bit, wrapping modulo 2048.
  - mode 01: offsets are forced to 0 on the next tick.
  - mode 11: offsets hold.
  - mode 00: offsets hold.
  - frame_cnt increments on every tick in all modes.
- Stage 1 (registered), per layer k:
  - y_k = vcount + offset[k], 11-bit wrap.
  - cx = hcount[10:CELL_LOG2], cy = y_k[10:CELL_LOG2].
  - h_k = 16-bit value (cx*16'h9E37) ^ (cy*16'h7F4B) ^ SEED ^ (k<<12), products truncated to 16 bits.
  - Register h_k, the local x/y coordinates within the cell, and the delayed timing signals.
- Stage 2 (registered), per layer k:
  - star_k = (h_k[15:12] < DENSITY) && local_x == h_k[CELL_LOG2-1:0] && local_y == h_k[2*CELL_LOG2-1:CELL_LOG2].
  - Layer colour: 12'hfff scaled by layer, i.e. k=0 12'hfff, k=1 12'haaa, k=2 12'h777, k=3 12'h444.
  - Twinkle: if (frame_cnt[5:4] ^ h_k[9:8]) == 0, the star colour is halved per channel (each 4-bit field >>1).
- rgb selection, in priority order:
  1. Any blanking delayed to stage 2: 12'h000.
  2. mode==00: BG_COLOR.
  3. Lowest-index layer with star_k=1 gives the star colour (layer 0 in front).
  4. Otherwise: BG_COLOR.
- Boundaries:
  - A mode change takes effect on the pixel path on the next clk (visible 2 clk later) and on scroll only at the next tick.
  - A tick coinciding with an active pixel is not possible in legal timing; no special case is required.
  - Offset wrap is seamless because 2048 is a multiple of the cell size.
  - Reset mid-frame clears outputs immediately; normal output resumes 2 clk after release.

Decomposition:
- vga_pkg: add RGB444 typedef, the layer colour constant array, hash multiplier constants, and the mode enum (MODE_SOLID, MODE_STATIC, MODE_SCROLL, MODE_FREEZE).
- One sub-module, star_hash: a pure-combinational 16-bit hash of (cx, cy, layer) to h, instantiated NUM_LAYERS times inside a generate loop.

Test Plan:
- Reset: hold rst 3 clk with toggling inputs -> every vga_out field 0; after release, the first valid output appears exactly 2 clk after its input.
- mode=00, active pixel at hcount=100, vcount=50 -> rgb=BG_COLOR 12'h001 two clk later; any blanking -> 12'h000.
- mode=01, DENSITY=16: sweep one cell at cx=0, cy=0 -> exactly one star pixel per layer at the position predicted by the reference hash model; layer 0 drawn as 12'hfff (or 12'h777 when twinkled) where layers overlap.
- mode=10: drive 4 vsync rising edges -> offset[0]=4, offset[1]=8, offset[2]=12; the star pattern of layer 1 appears shifted by 8 lines versus a mode=01 capture.
- mode=11 after 4 scrolling frames -> offsets stay at 4/8/12 over 3 further ticks while frame_cnt reaches 7; twinkle pattern changes when frame_cnt crosses 16.
- Wrap: preload 1024 ticks in mode=10 -> offset[1] = 2048 mod 2048 = 0 and the star image matches a fresh static frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and constants.
// Holds colours, hash multipliers and the starfield mode encoding.
package vga_pkg;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'b00,
        MODE_STATIC = 2'b01,
        MODE_SCROLL = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    localparam logic [15:0] HASH_MUL_X = 16'h9E37;
    localparam logic [15:0] HASH_MUL_Y = 16'h7F4B;

    localparam rgb444_t LAYER_COLOR [4] = '{
        12'hfff, 12'haaa, 12'h777, 12'h444
    };

    // Halve each 4-bit channel of an RGB444 value.
    function automatic rgb444_t rgb_halve(input rgb444_t c);
        return (c >> 1) & 12'h777;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel bus carried between pipeline stages.
// Timing fields plus RGB444 colour.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/draw_bg_starfield_star_hash.sv
// Combinational per-layer cell hash for the starfield.
// Products are deliberately truncated to 16 bits.
module star_hash
    import vga_pkg::*;
#(
    parameter int          CW   = 7,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic [CW-1:0] cx,
    input  logic [CW-1:0] cy,
    input  logic [1:0]    layer,
    output logic [15:0]   h
);

    logic [15:0] px;
    logic [15:0] py;

    assign px = 16'(cx) * HASH_MUL_X;
    assign py = 16'(cy) * HASH_MUL_Y;
    assign h  = px ^ py ^ SEED ^ {2'b00, layer, 12'h000};

endmodule

// File: rtl/draw_bg_starfield.sv
// Background stage: solid colour plus scrolling, twinkling star layers.
// Two-stage pixel pipeline; timing signals delayed to match.
module draw_bg_starfield
    import vga_pkg::*;
#(
    parameter logic [11:0] BG_COLOR   = 12'h0_0_1,
    parameter int          NUM_LAYERS = 3,
    parameter int          CELL_LOG2  = 4,
    parameter int          DENSITY    = 3,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [1:0]  mode,
    vga_if.out          vga_out
);

    localparam int CL = CELL_LOG2;
    localparam int CW = 11 - CELL_LOG2;

    mode_t md;
    logic  vsync_d;
    logic  tick;
    logic [7:0]  frame_cnt;
    logic [10:0] offset [NUM_LAYERS];

    assign md   = mode_t'(mode);
    assign tick = vsync & ~vsync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d   <= 1'b0;
            frame_cnt <= '0;
            for (int k = 0; k < NUM_LAYERS; k++)
                offset[k] <= '0;
        end else begin
            vsync_d <= vsync;
            if (tick) begin
                frame_cnt <= frame_cnt + 8'd1;
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    case (md)
                        MODE_SCROLL: offset[k] <= offset[k] + 11'(k + 1);
                        MODE_STATIC: offset[k] <= '0;
                        default:     offset[k] <= offset[k];
                    endcase
                end
            end
        end
    end

    logic [15:0]   h_c  [NUM_LAYERS];
    logic [CL-1:0] ly_c [NUM_LAYERS];

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        logic [10:0] y;
        assign y       = vcount + offset[k];
        assign ly_c[k] = y[CL-1:0];
        star_hash #(.CW(CW), .SEED(SEED)) u_hash (
            .cx    (hcount[10:CL]),
            .cy    (y[10:CL]),
            .layer (2'(k)),
            .h     (h_c[k])
        );
    end

    logic [15:0]   h_s1  [NUM_LAYERS];
    logic [CL-1:0] ly_s1 [NUM_LAYERS];
    logic [CL-1:0] lx_s1;
    mode_t         md_s1;
    logic [10:0]   hcount_s1, vcount_s1;
    logic          hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                h_s1[k]  <= '0;
                ly_s1[k] <= '0;
            end
            lx_s1     <= '0;
            md_s1     <= MODE_SOLID;
            hcount_s1 <= '0;
            vcount_s1 <= '0;
            hsync_s1  <= 1'b0;
            vsync_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                h_s1[k]  <= h_c[k];
                ly_s1[k] <= ly_c[k];
            end
            lx_s1     <= hcount[CL-1:0];
            md_s1     <= md;
            hcount_s1 <= hcount;
            vcount_s1 <= vcount;
            hsync_s1  <= hsync;
            vsync_s1  <= vsync;
            hblnk_s1  <= hblnk;
            vblnk_s1  <= vblnk;
        end
    end

    logic [NUM_LAYERS-1:0] star;
    rgb444_t               col [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] hash_unused;
    rgb444_t               rgb_c;

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_pix
        logic twinkle;
        assign twinkle = (frame_cnt[5:4] ^ h_s1[k][9:8]) == 2'b00;
        assign star[k] = ({1'b0, h_s1[k][15:12]} < 5'(DENSITY))
                      && lx_s1 == h_s1[k][CL-1:0]
                      && ly_s1[k] == h_s1[k][2*CL-1:CL];
        assign col[k]  = twinkle ? rgb_halve(LAYER_COLOR[k])
                                 : LAYER_COLOR[k];
        assign hash_unused[k] = ^h_s1[k];
    end

    // Walk from the back layer forward so layer 0 wins overlaps.
    always_comb begin
        rgb_c = BG_COLOR;
        for (int k = NUM_LAYERS - 1; k >= 0; k--)
            if (star[k])
                rgb_c = col[k];
        if (md_s1 == MODE_SOLID)
            rgb_c = BG_COLOR;
        if (hblnk_s1 | vblnk_s1)
            rgb_c = 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= hcount_s1;
            vga_out.vcount <= vcount_s1;
            vga_out.hsync  <= hsync_s1;
            vga_out.vsync  <= vsync_s1;
            vga_out.hblnk  <= hblnk_s1;
            vga_out.vblnk  <= vblnk_s1;
            vga_out.rgb    <= rgb_c;
        end
    end

endmodule

// File: tb/tb_draw_bg_starfield.sv
// Directed bench for draw_bg_starfield with DENSITY=16 (a star in every cell).
// Expected colours are hand-derived from the cell hash.
module tb_draw_bg_starfield;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic        hblnk = 1'b0;
    logic        vblnk = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [1:0]  mode = 2'b00;

    int total = 0;
    int bad   = 0;

    vga_if vif ();

    draw_bg_starfield #(.DENSITY(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .hcount  (hcount),
        .vcount  (vcount),
        .hblnk   (hblnk),
        .vblnk   (vblnk),
        .hsync   (hsync),
        .vsync   (vsync),
        .mode    (mode),
        .vga_out (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one pixel and wait out the two-stage latency.
    task automatic drive(input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic vb, input logic hs);
        @(negedge clk);
        hcount = h;
        vcount = v;
        hblnk  = hb;
        vblnk  = vb;
        hsync  = hs;
        vsync  = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pix(input string tag, input logic [10:0] h,
                       input logic [10:0] v, input logic [11:0] exp);
        drive(h, v, 1'b0, 1'b0, 1'b0);
        chk(tag, {4'h0, vif.rgb}, {4'h0, exp});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vsync = 1'b1;
            vblnk = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
            vblnk = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int stars;

        // Reset with busy inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hcount = 11'($urandom_range(0, 2047));
            vcount = 11'($urandom_range(0, 2047));
            hblnk  = 1'($urandom_range(0, 1));
            vblnk  = 1'($urandom_range(0, 1));
            hsync  = 1'($urandom_range(0, 1));
            vsync  = 1'($urandom_range(0, 1));
            mode   = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        chk("rst_rgb", {4'h0, vif.rgb}, 16'h0);
        chk("rst_hcount", {5'h0, vif.hcount}, 16'h0);
        chk("rst_vcount", {5'h0, vif.vcount}, 16'h0);
        chk("rst_flags", {12'h0, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk},
            16'h0);

        // Release with the first pixel already presented.
        rst    = 1'b0;
        mode   = 2'b00;
        hcount = 11'd100;
        vcount = 11'd50;
        hblnk  = 1'b0;
        vblnk  = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b0;
        @(negedge clk);
        chk("lat1_hcount", {5'h0, vif.hcount}, 16'h0);
        @(negedge clk);
        chk("lat2_hcount", {5'h0, vif.hcount}, 16'd100);
        chk("lat2_vcount", {5'h0, vif.vcount}, 16'd50);
        chk("solid_rgb", {4'h0, vif.rgb}, 16'h001);

        drive(11'd100, 11'd50, 1'b1, 1'b0, 1'b1);
        chk("hblnk_rgb", {4'h0, vif.rgb}, 16'h000);
        chk("hsync_pass", {15'h0, vif.hsync}, 16'h1);
        drive(11'd100, 11'd50, 1'b0, 1'b1, 1'b0);
        chk("vblnk_rgb", {4'h0, vif.rgb}, 16'h000);
        pix("solid_star_pos", 11'd1, 11'd14, 12'h001);

        // Static: all layers hash to (1,14) in cell (0,0); layer 0 twinkled.
        mode = 2'b01;
        pix("static_star", 11'd1, 11'd14, 12'h777);
        pix("static_bg", 11'd2, 11'd14, 12'h001);
        stars = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                drive(11'(x), 11'(y), 1'b0, 1'b0, 1'b0);
                if (vif.rgb != 12'h001)
                    stars++;
            end
        chk("static_sweep", 16'(stars), 16'd1);

        // Scroll 4 frames: offsets 4/8/12, frame_cnt 4.
        mode = 2'b10;
        ticks(4);
        pix("scroll_l1", 11'd1, 11'd6, 12'h555);
        pix("scroll_old", 11'd1, 11'd14, 12'h001);
        pix("scroll_l0", 11'd1, 11'd10, 12'h777);
        pix("scroll_l2", 11'd1, 11'd2, 12'h333);
        pix("blank_star", 11'd1, 11'd6, 12'h555);
        drive(11'd1, 11'd6, 1'b1, 1'b0, 1'b0);
        chk("blank_over_star", {4'h0, vif.rgb}, 16'h000);

        // Frozen: offsets hold, frame_cnt 7 then 16 clears twinkle.
        mode = 2'b11;
        ticks(3);
        pix("freeze_l1", 11'd1, 11'd6, 12'h555);
        pix("freeze_l2", 11'd1, 11'd2, 12'h333);
        ticks(9);
        pix("fc16_l1", 11'd1, 11'd6, 12'haaa);
        pix("fc16_l0", 11'd1, 11'd10, 12'hfff);
        pix("fc16_l2", 11'd1, 11'd2, 12'h777);

        // Static tick zeroes offsets (frame_cnt 17).
        mode = 2'b01;
        ticks(1);
        pix("rezero_star", 11'd1, 11'd14, 12'hfff);

        // 1024 scroll frames: offsets 1024/0/1024, frame_cnt 17.
        mode = 2'b10;
        ticks(1024);
        pix("wrap_l1", 11'd1, 11'd14, 12'haaa);
        pix("wrap_l0", 11'd1, 11'd2, 12'hfff);

        mode = 2'b00;
        pix("solid_again", 11'd1, 11'd2, 12'h001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
